// File: rtl/ifu_fetch_pkg.sv
// Shared fetch-unit definitions: address/instruction widths, FSM state encoding, NOP and fault bits.
// Latency: n/a (package).
// Backpressure: n/a (package).
package ifu_fetch_pkg;

    localparam int XLEN_DEFAULT = 64;
    localparam int ILEN_DEFAULT = 32;

    // pc_gen comes out of reset pointing here
    localparam logic [63:0] RESET_VECTOR = 64'h0000_0000_8000_0000;

    // addi x0, x0, 0 -- presented to decode whenever a fault is flagged
    localparam logic [31:0] INST_NOP = 32'h0000_0013;

    // bit positions inside inst_fault
    localparam int FAULT_ACCESS   = 0;
    localparam int FAULT_MISALIGN = 1;

    typedef enum logic [2:0] {
        IFU_IDLE  = 3'd0,
        IFU_REQ   = 3'd1,
        IFU_WAIT  = 3'd2,
        IFU_DRAIN = 3'd3,
        IFU_HOLD  = 3'd4
    } ifu_state_e;

    // instructions are 4-byte aligned; no compressed support
    function automatic logic pc_misaligned(input logic [1:0] pc_lo);
        return pc_lo != 2'b00;
    endfunction

endpackage

// File: rtl/dff.sv
// Enable flop with synchronous active-low reset to a parameterised value.
// Latency: 1 cycle from d_i to q_o when en_i is high.
// Backpressure: none; holds q_o while en_i is low.
// Ports: clk, rstn, en_i (load enable), d_i (next value), q_o (registered value).
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rstn,
    input  logic         en_i,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    always_ff @(posedge clk) begin
        if (!rstn) begin
            q_o <= RST_VAL;
        end else if (en_i) begin
            q_o <= d_i;
        end
    end

endmodule

// File: rtl/ifu_ibuf.sv
// One-entry instruction buffer between the fetch FSM and decode (inst, pc, fault, valid).
// Latency: 1 cycle from load_i to valid_o; clear/flush take effect on the next edge.
// Backpressure: the owner must not load while valid_o is high; drop (clear/flush) beats load.
// Ports: load_i/inst_i/pc_i/fault_i write the entry; clear_i (consumed) and flush_i (redirect)
//        both empty it back to NOP/0; valid_o/inst_o/pc_o/fault_o are the registered contents.
module ifu_ibuf
    import ifu_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int ILEN = ILEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic            load_i,
    input  logic            clear_i,
    input  logic            flush_i,
    input  logic [ILEN-1:0] inst_i,
    input  logic [XLEN-1:0] pc_i,
    input  logic [1:0]      fault_i,
    output logic            valid_o,
    output logic [ILEN-1:0] inst_o,
    output logic [XLEN-1:0] pc_o,
    output logic [1:0]      fault_o
);

    localparam logic [ILEN-1:0] NOP = ILEN'(INST_NOP);

    logic            drop;
    logic            en;
    logic            valid_d;
    logic [ILEN-1:0] inst_d;
    logic [XLEN-1:0] pc_d;
    logic [1:0]      fault_d;

    // an emptied entry looks exactly like the reset entry
    assign drop    = clear_i | flush_i;
    assign en      = load_i | drop;
    assign valid_d = load_i & ~drop;
    assign inst_d  = drop ? NOP : inst_i;
    assign pc_d    = drop ? '0 : pc_i;
    assign fault_d = drop ? 2'b00 : fault_i;

    dff #(.W(1), .RST_VAL(1'b0)) u_valid (
        .clk (clk), .rstn(rstn), .en_i(en), .d_i(valid_d), .q_o(valid_o)
    );

    dff #(.W(ILEN), .RST_VAL(NOP)) u_inst (
        .clk (clk), .rstn(rstn), .en_i(en), .d_i(inst_d), .q_o(inst_o)
    );

    dff #(.W(XLEN), .RST_VAL('0)) u_pc (
        .clk (clk), .rstn(rstn), .en_i(en), .d_i(pc_d), .q_o(pc_o)
    );

    dff #(.W(2), .RST_VAL(2'b00)) u_fault (
        .clk (clk), .rstn(rstn), .en_i(en), .d_i(fault_d), .q_o(fault_o)
    );

endmodule

// File: rtl/ifu_fetch.sv
// Instruction fetch: latches pc, issues one imem read, buffers the reply for decode, pulses pc_advance.
// Latency: request 1 cycle after IDLE; inst_valid 1 cycle after the response; 4 cycles/inst at zero wait.
// Backpressure: request held stable until imem_req_ready; inst held until inst_ready; flush aborts.
// Ports: pc/flush from pc_gen; imem_req_* / imem_rsp_* to instruction memory (one outstanding);
//        inst_valid/inst_ready/inst/inst_pc/inst_fault to decode; pc_advance back to pc_gen.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter int XLEN = XLEN_DEFAULT,
    parameter int ILEN = ILEN_DEFAULT
) (
    input  logic            clk,
    input  logic            rstn,
    input  logic [XLEN-1:0] pc,
    input  logic            flush,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [ILEN-1:0] imem_rsp_data,
    input  logic            imem_rsp_err,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [ILEN-1:0] inst,
    output logic [XLEN-1:0] inst_pc,
    output logic [1:0]      inst_fault,
    output logic            pc_advance
);

    ifu_state_e      state_q, state_d;
    logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;

    logic            buf_load;
    logic            buf_clear;
    logic            buf_flush;
    logic [ILEN-1:0] buf_inst;
    logic [XLEN-1:0] buf_pc;
    logic [1:0]      buf_fault;
    logic            adv;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state_q    <= IFU_IDLE;
            fetch_pc_q <= '0;
        end else begin
            state_q    <= state_d;
            fetch_pc_q <= fetch_pc_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        fetch_pc_d = fetch_pc_q;
        buf_load   = 1'b0;
        buf_clear  = 1'b0;
        buf_flush  = 1'b0;
        buf_inst   = ILEN'(INST_NOP);
        buf_pc     = fetch_pc_q;
        buf_fault  = 2'b00;
        adv        = 1'b0;

        case (state_q)
            IFU_IDLE: begin
                // pc only carries the redirect target from the cycle after flush,
                // so a flush here means the value on pc is stale: wait a cycle.
                if (!flush) begin
                    fetch_pc_d = pc;
                    if (pc_misaligned(pc[1:0])) begin
                        buf_load                  = 1'b1;
                        buf_pc                    = pc;
                        buf_fault[FAULT_MISALIGN] = 1'b1;
                        state_d                   = IFU_HOLD;
                    end else begin
                        state_d = IFU_REQ;
                    end
                end
            end

            IFU_REQ: begin
                if (imem_req_ready) begin
                    // accepted together with a flush: the reply is still owed
                    state_d = flush ? IFU_DRAIN : IFU_WAIT;
                end else if (flush) begin
                    state_d = IFU_IDLE;
                end
            end

            IFU_WAIT: begin
                if (imem_rsp_valid) begin
                    if (flush) begin
                        state_d = IFU_IDLE;
                    end else begin
                        buf_load                = 1'b1;
                        buf_fault[FAULT_ACCESS] = imem_rsp_err;
                        buf_inst                = imem_rsp_err ? ILEN'(INST_NOP) : imem_rsp_data;
                        state_d                 = IFU_HOLD;
                    end
                end else if (flush) begin
                    state_d = IFU_DRAIN;
                end
            end

            IFU_DRAIN: begin
                if (imem_rsp_valid) begin
                    state_d = IFU_IDLE;
                end
            end

            IFU_HOLD: begin
                if (flush) begin
                    buf_flush = 1'b1;
                    state_d   = IFU_IDLE;
                end else if (inst_ready) begin
                    buf_clear = 1'b1;
                    adv       = 1'b1;
                    state_d   = IFU_IDLE;
                end
            end

            default: begin
                state_d = IFU_IDLE;
            end
        endcase
    end

    assign imem_req_valid = (state_q == IFU_REQ);
    assign imem_req_addr  = fetch_pc_q;
    assign pc_advance     = adv;

    ifu_ibuf #(
        .XLEN(XLEN),
        .ILEN(ILEN)
    ) u_ibuf (
        .clk     (clk),
        .rstn    (rstn),
        .load_i  (buf_load),
        .clear_i (buf_clear),
        .flush_i (buf_flush),
        .inst_i  (buf_inst),
        .pc_i    (buf_pc),
        .fault_i (buf_fault),
        .valid_o (inst_valid),
        .inst_o  (inst),
        .pc_o    (inst_pc),
        .fault_o (inst_fault)
    );

endmodule
